// File: rtl/segmentd_pkg.sv
// Shared types and constants for the segmentd 7-segment scan controller.
// Hex-letter patterns are used only when SEGMENTD_HEX_DECODE_EN is defined.
package segmentd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;

    localparam logic [3:0] CODE_DASH  = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd11;

endpackage

// File: rtl/segmentd_decode.sv
// Combinational nibble to active-low 7-segment decoder.
// Define SEGMENTD_HEX_DECODE_EN to show A..F for codes 10..15 instead of dash/blank.
module segmentd_decode
    import segmentd_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'd0:  o_seg = SEG_0;
            4'd1:  o_seg = SEG_1;
            4'd2:  o_seg = SEG_2;
            4'd3:  o_seg = SEG_3;
            4'd4:  o_seg = SEG_4;
            4'd5:  o_seg = SEG_5;
            4'd6:  o_seg = SEG_6;
            4'd7:  o_seg = SEG_7;
            4'd8:  o_seg = SEG_8;
            4'd9:  o_seg = SEG_9;
`ifdef SEGMENTD_HEX_DECODE_EN
            4'd10: o_seg = SEG_A;
            4'd11: o_seg = SEG_B;
            4'd12: o_seg = SEG_C;
            4'd13: o_seg = SEG_D;
            4'd14: o_seg = SEG_E;
            4'd15: o_seg = SEG_F;
`else
            CODE_DASH:  o_seg = SEG_DASH;
            CODE_BLANK: o_seg = SEG_BLANK;
`endif
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/segmentd_scan.sv
// Multiplexed 7-segment scan controller with blanking dead time between digits.
// Optional hex letters via SEGMENTD_HEX_DECODE_EN (handled in segmentd_decode).
module segmentd_scan
    import segmentd_pkg::*;
#(
    parameter int NUM_DIGITS   = 5,
    parameter int DIV_WIDTH    = 16,
    parameter int DIV_TERM     = 49999,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [3:0]            mux_in,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [2:0]            seg_mux_sel,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_tick
);

    localparam logic [DIV_WIDTH-1:0] LP_DIV_LAST   = DIV_WIDTH'(DIV_TERM);
    localparam logic [DIV_WIDTH-1:0] LP_BLANK_LAST = DIV_WIDTH'(BLANK_CYCLES - 1);
    localparam logic [2:0]           LP_SEL_LAST   = 3'(NUM_DIGITS - 1);

    scan_state_t           r_state;
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic [2:0]            r_sel;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic                  r_frame_tick;
    logic [6:0]            w_dec;

    segmentd_decode u_decode (
        .i_nibble (mux_in),
        .o_seg    (w_dec)
    );

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sel        <= '0;
            r_an         <= '1;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            if (!en) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_sel   <= '0;
                r_an    <= '1;
                r_seg   <= SEG_BLANK;
                r_dp    <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cnt   <= '0;
                        r_state <= BLANK;
                    end
                    BLANK: begin
                        // mux_in is valid now since seg_mux_sel was updated on entry
                        if (r_cnt == LP_BLANK_LAST) begin
                            r_seg   <= w_dec;
                            r_dp    <= ~dp_mask[r_sel];
                            r_an    <= ~(NUM_DIGITS'(1) << r_sel);
                            r_cnt   <= '0;
                            r_state <= SHOW;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    SHOW: begin
                        if (r_cnt == LP_DIV_LAST) begin
                            r_sel        <= (r_sel == LP_SEL_LAST) ? 3'd0 : r_sel + 3'd1;
                            r_frame_tick <= (r_sel == LP_SEL_LAST);
                            r_an         <= '1;
                            r_seg        <= SEG_BLANK;
                            r_dp         <= 1'b1;
                            r_cnt        <= '0;
                            r_state      <= BLANK;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign seg_mux_sel = r_sel;
    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = r_dp;
    assign frame_tick  = r_frame_tick;

endmodule
